// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, frame-locking arbiter in front of a single UART transmitter
//
// Ports:
//   clk, rst       system clock, asynchronous active-high reset
//   req            per-requester byte request, held until acked
//   req_data       byte of requester i at [8i+7:8i]
//   req_last       byte is the final byte of its frame
//   req_ack        one-cycle accept pulse, coincides with start_tx
//   tx_idle_ready  uart idle_ready_tx
//   start_tx       one-cycle pulse to uart start_tx
//   data_tx        byte to uart data_tx, holds after start_tx falls
//   grant_id       index of the last or current grantee
//   locked         a multi-byte frame holds the grant
//   timeout_flag   one-cycle pulse when an abandoned lock is released
//                  (only when UART_TX_ARBITER_TIMEOUT_EN is defined)
//
// Build option: UART_TX_ARBITER_TIMEOUT_EN adds the lock-release timeout.

module uart_tx_arbiter #(
    parameter int N_REQ          = 4,
    parameter int GUARD_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [8*N_REQ-1:0]       req_data,
    input  logic [N_REQ-1:0]         req_last,
    output logic [N_REQ-1:0]         req_ack,
    input  logic                     tx_idle_ready,
    output logic                     start_tx,
    output logic [7:0]               data_tx,
    output logic [$clog2(N_REQ)-1:0] grant_id,
`ifdef UART_TX_ARBITER_TIMEOUT_EN
    output logic                     timeout_flag,
`endif
    output logic                     locked
);

    localparam int IDW = $clog2(N_REQ);
    localparam int GW  = $clog2(GUARD_CYCLES + 1);

    localparam logic [1:0] ST_ARB   = 2'd0;
    localparam logic [1:0] ST_GUARD = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    // Elaboration-time parameter sanity checks.
    if (N_REQ < 2) begin : g_bad_n_req
        $error("uart_tx_arbiter: N_REQ must be >= 2");
    end
    if (GUARD_CYCLES < 1) begin : g_bad_guard
        $error("uart_tx_arbiter: GUARD_CYCLES must be >= 1");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("uart_tx_arbiter: TIMEOUT_CYCLES must be >= 1");
    end

    logic [1:0]       state_q, state_d;
    logic [GW-1:0]    guard_q, guard_d;
    logic             start_q, start_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic [7:0]       data_q, data_d;
    logic [IDW-1:0]   grant_q, grant_d;
    logic             locked_q, locked_d;

    logic [N_REQ-1:0] lock_mask;
    logic [N_REQ-1:0] elig;
    logic             found;
    logic [IDW-1:0]   winner;

`ifdef UART_TX_ARBITER_TIMEOUT_EN
    localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TOW-1:0] to_cnt_q, to_cnt_d;
    logic           tflag_q, tflag_d;
`endif

    // While a frame is in progress only the owner is eligible, even if its
    // req is currently low; other requesters simply wait.
    always_comb begin
        lock_mask          = '0;
        lock_mask[grant_q] = 1'b1;
        elig               = locked_q ? (req & lock_mask) : req;
    end

    // Round-robin search starting one past the last grantee.
    always_comb begin
        found  = 1'b0;
        winner = grant_q;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!found && elig[(int'(grant_q) + k) % N_REQ]) begin
                found  = 1'b1;
                winner = IDW'((int'(grant_q) + k) % N_REQ);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        guard_d  = guard_q;
        start_d  = 1'b0;
        ack_d    = '0;
        data_d   = data_q;
        grant_d  = grant_q;
        locked_d = locked_q;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
        to_cnt_d = to_cnt_q;
        tflag_d  = 1'b0;
`endif
        case (state_q)
            ST_ARB: begin
                if (tx_idle_ready && found) begin
                    data_d        = req_data[8*int'(winner) +: 8];
                    start_d       = 1'b1;
                    ack_d[winner] = 1'b1;
                    grant_d       = winner;
                    locked_d      = ~req_last[winner];
                    guard_d       = GW'(GUARD_CYCLES);
                    state_d       = ST_GUARD;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
                    to_cnt_d      = '0;
`endif
                end
`ifdef UART_TX_ARBITER_TIMEOUT_EN
                else if (locked_q && !req[grant_q]) begin
                    // Owner went quiet mid-frame: release the lock after
                    // TIMEOUT_CYCLES idle ARB cycles, keeping grant_id so
                    // round-robin continues past the stalled owner.
                    if (to_cnt_q == TOW'(TIMEOUT_CYCLES - 1)) begin
                        locked_d = 1'b0;
                        tflag_d  = 1'b1;
                        to_cnt_d = '0;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
`endif
            end
            ST_GUARD: begin
                // tx_idle_ready is ignored here so the uart's deassert
                // latency cannot be mistaken for a finished byte.
                if (guard_q <= GW'(1)) begin
                    guard_d = '0;
                    state_d = ST_WAIT;
                end else begin
                    guard_d = guard_q - 1'b1;
                end
            end
            ST_WAIT: begin
                if (tx_idle_ready) begin
                    state_d = ST_ARB;
                end
            end
            default: begin
                state_d = ST_ARB;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_ARB;
            guard_q  <= '0;
            start_q  <= 1'b0;
            ack_q    <= '0;
            data_q   <= '0;
            grant_q  <= IDW'(N_REQ - 1);
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            guard_q  <= guard_d;
            start_q  <= start_d;
            ack_q    <= ack_d;
            data_q   <= data_d;
            grant_q  <= grant_d;
            locked_q <= locked_d;
        end
    end

`ifdef UART_TX_ARBITER_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_q <= '0;
            tflag_q  <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            tflag_q  <= tflag_d;
        end
    end

    assign timeout_flag = tflag_q;
`endif

    assign start_tx = start_q;
    assign req_ack  = ack_q;
    assign data_tx  = data_q;
    assign grant_id = grant_q;
    assign locked   = locked_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter

module tb_uart_tx_arbiter;

    localparam int N = 4;
    localparam int G = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ack;
    logic        tx_idle_ready;
    logic        start_tx;
    logic [7:0]  data_tx;
    logic [1:0]  grant_id;
    logic        locked;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
    logic        timeout_flag;
`endif

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N_REQ(N),
        .GUARD_CYCLES(G),
        .TIMEOUT_CYCLES(1024)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .req_data(req_data),
        .req_last(req_last),
        .req_ack(req_ack),
        .tx_idle_ready(tx_idle_ready),
        .start_tx(start_tx),
        .data_tx(data_tx),
        .grant_id(grant_id),
`ifdef UART_TX_ARBITER_TIMEOUT_EN
        .timeout_flag(timeout_flag),
`endif
        .locked(locked)
    );

    typedef struct packed {
        logic [7:0] data;
        logic [3:0] ack;
        logic [1:0] grant;
        logic       locked;
    } exp_t;

    typedef struct packed {
        logic [1:0] idx;
        logic [7:0] data;
        logic       last;
        exp_t       exp;
    } vec_t;

    exp_t expq[$];
    vec_t vecs[7];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_start = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] d, input int idx, input logic lk);
        exp_t e;
        e.data   = d;
        e.ack    = 4'b0001 << idx;
        e.grant  = 2'(idx);
        e.locked = lk;
        return e;
    endfunction

    task automatic wait_ack(input int idx);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ack[idx] && n < 200);
        if (!req_ack[idx]) check($sformatf("ack%0d_timeout", idx), {31'd0, req_ack[idx]}, 1);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Scoreboard: every start_tx pops the oldest expected transfer.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            last_start = -1;
        end else if (start_tx) begin
            if (expq.size() == 0) begin
                check("start_with_empty_queue", expq.size(), 1);
            end else begin
                exp_t e;
                e = expq.pop_front();
                check("data_tx", {24'd0, data_tx}, {24'd0, e.data});
                check("req_ack", {28'd0, req_ack}, {28'd0, e.ack});
                check("grant_id", {30'd0, grant_id}, {30'd0, e.grant});
                check("locked", {31'd0, locked}, {31'd0, e.locked});
            end
            if (last_start >= 0) check("spacing_ok", 32'((cyc - last_start) >= G + 2), 1);
            last_start = cyc;
        end else if (req_ack != 4'd0) begin
            check("ack_without_start", {28'd0, req_ack}, 0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int stray;

        vecs[0] = '{2'd2, 8'h41, 1'b1, '{8'h41, 4'b0100, 2'd2, 1'b0}};
        vecs[1] = '{2'd0, 8'h12, 1'b1, '{8'h12, 4'b0001, 2'd0, 1'b0}};
        vecs[2] = '{2'd3, 8'hA5, 1'b0, '{8'hA5, 4'b1000, 2'd3, 1'b1}};
        vecs[3] = '{2'd3, 8'h5A, 1'b1, '{8'h5A, 4'b1000, 2'd3, 1'b0}};
        vecs[4] = '{2'd1, 8'h77, 1'b1, '{8'h77, 4'b0010, 2'd1, 1'b0}};
        vecs[5] = '{2'd1, 8'hE0, 1'b0, '{8'hE0, 4'b0010, 2'd1, 1'b1}};
        vecs[6] = '{2'd1, 8'hE1, 1'b1, '{8'hE1, 4'b0010, 2'd1, 1'b0}};

        rst = 1'b1;
        req = '0;
        req_data = '0;
        req_last = '0;
        tx_idle_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_start_tx", {31'd0, start_tx}, 0);
        check("rst_data_tx", {24'd0, data_tx}, 0);
        check("rst_req_ack", {28'd0, req_ack}, 0);
        check("rst_locked", {31'd0, locked}, 0);
        check("rst_grant_id", {30'd0, grant_id}, 3);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single-requester vectors: one-cycle latency from ARB with idle ready.
        for (int i = 0; i < 7; i++) begin
            req_data[8*vecs[i].idx +: 8] = vecs[i].data;
            req_last[vecs[i].idx] = vecs[i].last;
            req[vecs[i].idx] = 1'b1;
            expq.push_back(vecs[i].exp);
            @(negedge clk);
            check($sformatf("latency_v%0d", i), {31'd0, start_tx}, 1);
            if (!req_ack[vecs[i].idx]) wait_ack(int'(vecs[i].idx));
            req[vecs[i].idx] = 1'b0;
            repeat (6) @(negedge clk);
        end

        // Round-robin from reset with req=1011 held.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        req_data = {8'h83, 8'h82, 8'h81, 8'h80};
        req_last = 4'hF;
        expq.push_back(mk(8'h80, 0, 1'b0));
        expq.push_back(mk(8'h81, 1, 1'b0));
        expq.push_back(mk(8'h83, 3, 1'b0));
        expq.push_back(mk(8'h80, 0, 1'b0));
        expq.push_back(mk(8'h81, 1, 1'b0));
        expq.push_back(mk(8'h83, 3, 1'b0));
        req = 4'b1011;
        k = 0;
        for (int c = 0; c < 200 && k < 6; c++) begin
            @(negedge clk);
            if (req_ack != 4'd0) k++;
        end
        req = '0;
        check("rr_grants", k, 6);
        repeat (6) @(negedge clk);

        // Frame lock: req1 frame 09,F6 with req0 pending and req1 silent mid-frame.
        req_data[15:8] = 8'h09;
        req_last[1] = 1'b0;
        req[1] = 1'b1;
        expq.push_back(mk(8'h09, 1, 1'b1));
        wait_ack(1);
        req[1] = 1'b0;
        req_data[7:0] = 8'h30;
        req_last[0] = 1'b1;
        req[0] = 1'b1;
        stray = 0;
        repeat (12) begin
            @(negedge clk);
            if (start_tx) stray++;
        end
        check("lock_blocks_others", stray, 0);
        check("locked_owner_idle", {31'd0, locked}, 1);
        req_data[15:8] = 8'hF6;
        req_last[1] = 1'b1;
        req[1] = 1'b1;
        expq.push_back(mk(8'hF6, 1, 1'b0));
        expq.push_back(mk(8'h30, 0, 1'b0));
        wait_ack(1);
        req[1] = 1'b0;
        wait_ack(0);
        req[0] = 1'b0;
        repeat (6) @(negedge clk);

        // Back-pressure: no transfer while the uart is busy.
        tx_idle_ready = 1'b0;
        req_data[7:0] = 8'h55;
        req[0] = 1'b1;
        stray = 0;
        repeat (50) begin
            @(negedge clk);
            if (start_tx) stray++;
        end
        check("bp_no_start", stray, 0);
        expq.push_back(mk(8'h55, 0, 1'b0));
        tx_idle_ready = 1'b1;
        @(negedge clk);
        check("bp_start_next_edge", {31'd0, start_tx}, 1);
        if (!req_ack[0]) wait_ack(0);
        req[0] = 1'b0;
        repeat (6) @(negedge clk);

        // Asynchronous reset while locked in GUARD.
        req_data[23:16] = 8'hC3;
        req_last[2] = 1'b0;
        req[2] = 1'b1;
        expq.push_back(mk(8'hC3, 2, 1'b1));
        wait_ack(2);
        #1 rst = 1'b1;
        #1;
        check("arst_start_tx", {31'd0, start_tx}, 0);
        check("arst_req_ack", {28'd0, req_ack}, 0);
        check("arst_locked", {31'd0, locked}, 0);
        check("arst_grant_id", {30'd0, grant_id}, 3);
        check("arst_data_tx", {24'd0, data_tx}, 0);
        req_data[23:16] = 8'hC4;
        req_last[2] = 1'b1;
        req_data[7:0] = 8'h01;
        req_last[0] = 1'b1;
        req[0] = 1'b1;
        expq.push_back(mk(8'h01, 0, 1'b0));
        expq.push_back(mk(8'hC4, 2, 1'b0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_ack(0);
        req[0] = 1'b0;
        wait_ack(2);
        req[2] = 1'b0;

        repeat (10) @(negedge clk);
        check("queue_drained", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
